// File: rtl/avr_io_intc_pkg.sv
// Shared constants and register layout for the AVR I/O-space interrupt controller.
// Also used by the core-side top level for its address decode.
package avr_io_intc_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    // Register offsets within the 4-register window.
    typedef enum logic [AW-1:0] {
        INTC_IMSK  = 2'd0,
        INTC_IPEND = 2'd1,
        INTC_IMODE = 2'd2,
        INTC_ICTL  = 2'd3
    } intc_reg_e;

    localparam int unsigned ICTL_GIE       = 0;
    localparam int unsigned ICTL_IVECT_LSB = 4;
    localparam int unsigned ICTL_IFLAG     = 7;

    // ICTL read layout: iflag in bit 7, ivect in bits 6:4, GIE in bit 0.
    typedef struct packed {
        logic       iflag;
        logic [2:0] ivect;
        logic [2:0] rsvd;
        logic       gie;
    } ictl_t;

    function automatic logic [DW-1:0] ictl_pack(input logic iflag, input logic [2:0] ivect,
                                                input logic gie);
        ictl_t r;
        r.iflag = iflag;
        r.ivect = ivect;
        r.rsvd  = 3'b000;
        r.gie   = gie;
        return DW'(r);
    endfunction

endpackage

// File: rtl/avr_io_intc_if.sv
// I/O-space register bus between avr_core (master) and a peripheral (slave).
interface avr_io_intc_if;
    import avr_io_intc_pkg::*;

    logic          io_re;
    logic          io_we;
    logic [AW-1:0] io_a;
    logic [DW-1:0] io_di;
    logic [DW-1:0] io_do;

    modport master (output io_re, output io_we, output io_a, output io_di, input io_do);
    modport slave  (input io_re, input io_we, input io_a, input io_di, output io_do);

endinterface

// File: rtl/avr_prio_enc.sv
// Combinational lowest-index-first priority encoder; idx is 0 when no request is set.
module avr_prio_enc #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [W-1:0] idx
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/avr_io_intc.sv
// Interrupt controller: mask, edge/level mode, sticky pending and global enable,
// driving avr_core iflag/ivect and exposing IMSK/IPEND/IMODE/ICTL on the I/O bus.
module avr_io_intc
    import avr_io_intc_pkg::*;
#(
    parameter int unsigned NIRQ = 8,
    parameter int unsigned IVW  = 3,
    parameter int unsigned SYNC = 0
) (
    input  logic             clk,
    input  logic             rst,
    avr_io_intc_if.slave     bus,
    input  logic [NIRQ-1:0]  irq,
    input  logic             iack,
    output logic             iflag,
    output logic [IVW-1:0]   ivect
);

    logic [NIRQ-1:0] s;
    logic [NIRQ-1:0] prev_q, prev_d;
    logic [NIRQ-1:0] msk_q, msk_d;
    logic [NIRQ-1:0] mode_q, mode_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic            gie_q, gie_d;
    logic            iflag_q, iflag_d;
    logic [IVW-1:0]  ivect_q, ivect_d;
    logic [NIRQ-1:0] w1c, ack, active;
    logic            enc_any;
    logic [IVW-1:0]  enc_idx;
    logic [DW-1:0]   rdata_c;

    // Optional two-flop synchroniser for asynchronous irq sources.
    if (SYNC != 0) begin : g_sync
        logic [NIRQ-1:0] sync1_q, sync1_d;
        logic [NIRQ-1:0] sync2_q, sync2_d;

        always_comb begin
            sync1_d = irq;
            sync2_d = sync1_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
            end
        end

        assign s = sync2_q;
    end else begin : g_nosync
        assign s = irq;
    end

    assign active = pend_q & msk_q;

    avr_prio_enc #(
        .N (NIRQ),
        .W (IVW)
    ) u_enc (
        .req (active),
        .any (enc_any),
        .idx (enc_idx)
    );

    // Register writes, W1C/ack decode and pending update.
    always_comb begin
        msk_d  = msk_q;
        mode_d = mode_q;
        gie_d  = gie_q;
        w1c    = '0;
        ack    = '0;
        pend_d = pend_q;
        prev_d = s;

        if (bus.io_we) begin
            case (intc_reg_e'(bus.io_a))
                INTC_IMSK:  msk_d  = bus.io_di[NIRQ-1:0];
                INTC_IPEND: w1c    = bus.io_di[NIRQ-1:0];
                INTC_IMODE: mode_d = bus.io_di[NIRQ-1:0];
                INTC_ICTL:  gie_d  = bus.io_di[ICTL_GIE];
                default: ;
            endcase
        end

        for (int i = 0; i < int'(NIRQ); i++) begin
            ack[i] = iack && iflag_q && (ivect_q == IVW'(i));
            // A new edge beats a clear in the same cycle.
            if (mode_q[i]) pend_d[i] = (s[i] & ~prev_q[i]) | (pend_q[i] & ~(w1c[i] | ack[i]));
            else           pend_d[i] = s[i];
        end

        iflag_d = gie_q & enc_any;
        ivect_d = enc_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            msk_q   <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            gie_q   <= 1'b0;
            iflag_q <= 1'b0;
            ivect_q <= '0;
        end else begin
            prev_q  <= prev_d;
            msk_q   <= msk_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            gie_q   <= gie_d;
            iflag_q <= iflag_d;
            ivect_q <= ivect_d;
        end
    end

    // Same-cycle read data, forced to zero when not selected so it can be OR-ed onto the bus.
    always_comb begin
        rdata_c = '0;
        if (bus.io_re) begin
            case (intc_reg_e'(bus.io_a))
                INTC_IMSK:  rdata_c = DW'(msk_q);
                INTC_IPEND: rdata_c = DW'(pend_q);
                INTC_IMODE: rdata_c = DW'(mode_q);
                INTC_ICTL:  rdata_c = ictl_pack(iflag_q, 3'(ivect_q), gie_q);
                default: ;
            endcase
        end
    end

    assign bus.io_do = rdata_c;
    assign iflag     = iflag_q;
    assign ivect     = ivect_q;

endmodule

// File: tb/tb_avr_io_intc.sv
// Scoreboard bench for avr_io_intc: default 8-channel instance plus a synchronised 3-channel one.
module tb_avr_io_intc;
    import avr_io_intc_pkg::*;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_a = '0;
    logic       iack_a = 1'b0;
    logic       iflag_a;
    logic [2:0] ivect_a;
    logic [2:0] irq_b = '0;
    logic       iack_b = 1'b0;
    logic       iflag_b;
    logic [1:0] ivect_b;

    int n_chk  = 0;
    int n_pass = 0;
    exp_t sb_q[$];

    avr_io_intc_if bus_a ();
    avr_io_intc_if bus_b ();

    avr_io_intc #(.NIRQ(8), .IVW(3), .SYNC(0)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_a),
        .irq   (irq_a),
        .iack  (iack_a),
        .iflag (iflag_a),
        .ivect (ivect_a)
    );

    avr_io_intc #(.NIRQ(3), .IVW(2), .SYNC(1)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_b),
        .irq   (irq_b),
        .iack  (iack_b),
        .iflag (iflag_b),
        .ivect (ivect_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit b, input logic [1:0] a, input logic [7:0] d);
        if (b) begin bus_b.io_we = 1'b1; bus_b.io_a = a; bus_b.io_di = d; end
        else   begin bus_a.io_we = 1'b1; bus_a.io_a = a; bus_a.io_di = d; end
        tick(1);
        bus_a.io_we = 1'b0;
        bus_b.io_we = 1'b0;
    endtask

    // Expected read value goes on the scoreboard with the strobe; popped when io_do settles.
    task automatic rd(input bit b, input logic [1:0] a, input logic [7:0] exp, input string tag);
        exp_t e;
        e.tag = tag;
        e.val = exp;
        sb_q.push_back(e);
        if (b) begin bus_b.io_re = 1'b1; bus_b.io_a = a; end
        else   begin bus_a.io_re = 1'b1; bus_a.io_a = a; end
        #1;
        e = sb_q.pop_front();
        chk(e.tag, b ? bus_b.io_do : bus_a.io_do, e.val);
        bus_a.io_re = 1'b0;
        bus_b.io_re = 1'b0;
    endtask

    initial begin
        bus_a.io_re = 1'b0; bus_a.io_we = 1'b0; bus_a.io_a = '0; bus_a.io_di = '0;
        bus_b.io_re = 1'b0; bus_b.io_we = 1'b0; bus_b.io_a = '0; bus_b.io_di = '0;
        tick(2);
        rst = 1'b0;

        // Reset state and idle read data.
        rd(0, INTC_IMSK,  8'h00, "rst_imsk");
        rd(0, INTC_IPEND, 8'h00, "rst_ipend");
        rd(0, INTC_IMODE, 8'h00, "rst_imode");
        rd(0, INTC_ICTL,  8'h00, "rst_ictl");
        chk("idle_io_do", bus_a.io_do, 8'h00);
        irq_a = 8'hFF;
        tick(3);
        chk("masked_iflag", iflag_a, 1'b0);
        rd(0, INTC_IPEND, 8'hFF, "level_pend_all");
        irq_a = 8'h00;
        tick(2);

        // Edge latch on channel 2 and W1C.
        wr(0, INTC_IMODE, 8'h04);
        wr(0, INTC_IMSK,  8'h04);
        wr(0, INTC_ICTL,  8'h01);
        irq_a = 8'h04;
        tick(1);
        irq_a = 8'h00;
        chk("edge_iflag_1cyc", iflag_a, 1'b0);
        rd(0, INTC_IPEND, 8'h04, "edge_pend");
        tick(1);
        chk("edge_iflag", iflag_a, 1'b1);
        chk("edge_ivect", ivect_a, 3'd2);
        rd(0, INTC_ICTL, 8'hA1, "edge_ictl");
        wr(0, INTC_IPEND, 8'h04);
        rd(0, INTC_IPEND, 8'h00, "w1c_pend");
        tick(1);
        chk("w1c_iflag", iflag_a, 1'b0);

        // Priority between channels 1 and 3, then iack pops them in order.
        wr(0, INTC_IMSK,  8'h0A);
        wr(0, INTC_IMODE, 8'h0A);
        irq_a = 8'h0A;
        tick(1);
        irq_a = 8'h00;
        tick(1);
        chk("prio_iflag", iflag_a, 1'b1);
        chk("prio_ivect", ivect_a, 3'd1);
        iack_a = 1'b1;
        tick(1);
        iack_a = 1'b0;
        rd(0, INTC_IPEND, 8'h08, "ack1_pend");
        tick(1);
        chk("ack1_ivect", ivect_a, 3'd3);
        iack_a = 1'b1;
        tick(1);
        iack_a = 1'b0;
        rd(0, INTC_IPEND, 8'h00, "ack2_pend");
        tick(1);
        chk("ack2_iflag", iflag_a, 1'b0);
        chk("ack2_ivect", ivect_a, 3'd0);

        // Level channel 0: follows irq, W1C ignored.
        wr(0, INTC_IMODE, 8'h00);
        wr(0, INTC_IMSK,  8'h01);
        irq_a = 8'h01;
        tick(2);
        chk("lvl_iflag", iflag_a, 1'b1);
        wr(0, INTC_IPEND, 8'h01);
        rd(0, INTC_IPEND, 8'h01, "lvl_w1c_pend");
        tick(1);
        chk("lvl_w1c_iflag", iflag_a, 1'b1);
        irq_a = 8'h00;
        tick(1);
        chk("lvl_drop_1cyc", iflag_a, 1'b1);
        tick(1);
        chk("lvl_drop_2cyc", iflag_a, 1'b0);

        // Edge set collides with W1C of the same bit: set wins.
        wr(0, INTC_IMODE, 8'h20);
        wr(0, INTC_IMSK,  8'h20);
        irq_a = 8'h20;
        wr(0, INTC_IPEND, 8'h20);
        irq_a = 8'h00;
        rd(0, INTC_IPEND, 8'h20, "coll_pend");
        tick(1);
        chk("coll_iflag", iflag_a, 1'b1);
        chk("coll_ivect", ivect_a, 3'd5);

        // iack while iflag is low does nothing.
        wr(0, INTC_ICTL, 8'h00);
        tick(1);
        chk("gie_off_iflag", iflag_a, 1'b0);
        iack_a = 1'b1;
        tick(1);
        iack_a = 1'b0;
        rd(0, INTC_IPEND, 8'h20, "noflag_ack_pend");

        // Reset mid-operation.
        wr(0, INTC_ICTL, 8'h01);
        tick(1);
        chk("pre_rst_iflag", iflag_a, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("rst_iflag", iflag_a, 1'b0);
        rst = 1'b0;
        rd(0, INTC_IPEND, 8'h00, "rst_pend");
        rd(0, INTC_IMODE, 8'h00, "rst_mode2");

        // Synchronised 3-channel instance: 3-cycle latency and narrow registers.
        wr(1, INTC_IMODE, 8'h01);
        irq_b = 3'b001;
        tick(1);
        rd(1, INTC_IPEND, 8'h00, "sync_cyc1");
        tick(1);
        rd(1, INTC_IPEND, 8'h00, "sync_cyc2");
        tick(1);
        rd(1, INTC_IPEND, 8'h01, "sync_cyc3");
        irq_b = 3'b000;
        wr(1, INTC_IMSK, 8'hFF);
        rd(1, INTC_IMSK, 8'h07, "narrow_imsk");
        wr(1, INTC_IMODE, 8'hFF);
        rd(1, INTC_IMODE, 8'h07, "narrow_imode");
        wr(1, INTC_ICTL, 8'h01);
        tick(1);
        chk("sync_iflag", iflag_b, 1'b1);
        rd(1, INTC_ICTL, 8'h81, "sync_ictl");

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
